// File: rtl/fsm_mon_pkg.sv
// Shared types and widths for the maintenance-FSM state-bus monitor.
package fsm_mon_pkg;

    localparam int unsigned EVT_W    = 8;
    localparam int unsigned MANT_BIT = 7;
    localparam int unsigned MANT_W   = 7;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DROP_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        STALLED = 2'd2
    } mon_state_t;

endpackage

// File: rtl/mon_fifo.sv
// Show-ahead synchronous event FIFO; pointers carry one extra wrap bit.
module mon_fifo
    import fsm_mon_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [EVT_W-1:0] din,
    output logic [EVT_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wr_q, rd_q;
    logic [EVT_W-1:0]  mem [DEPTH];
    logic              do_pop, do_push;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // A pop on an empty FIFO is ignored; a full FIFO still accepts a push when it pops
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fsm_state_monitor.sv
// Watches the maintenance FSM state bus: queues changes, checks count sequence,
// flags overflow and a frozen bus.
module fsm_state_monitor
    import fsm_mon_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned STALL_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [EVT_W-1:0]  state_in,
    input  logic              clr_err,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [EVT_W-1:0]  evt_data,
    output logic [MANT_W-1:0] mant_last,
    output logic              stall,
    output logic              seq_err,
    output logic              ovf,
    output logic [DROP_W-1:0] drop_cnt
);

    mon_state_t        state_q, state_d;
    logic [EVT_W-1:0]  prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              has_mant_q;
    logic              change_c, push_c, cnt_clr_c, cnt_inc_c;
    logic              fifo_full, fifo_empty, drop_c, seq_bad_c;

    assign change_c = (state_in != prev_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = TRACK;
            TRACK:   if (!change_c && cnt_q == CNT_W'(STALL_CYCLES - 2)) state_d = STALLED;
            STALLED: if (change_c) state_d = TRACK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_c    = 1'b0;
        cnt_clr_c = 1'b0;
        cnt_inc_c = 1'b0;
        case (state_q)
            IDLE: begin
                push_c    = 1'b1;
                cnt_clr_c = 1'b1;
            end
            TRACK: begin
                push_c    = change_c;
                cnt_clr_c = change_c;
                cnt_inc_c = ~change_c;
            end
            STALLED: begin
                push_c    = change_c;
                cnt_clr_c = change_c;
            end
            default: ;
        endcase
    end

    // Drop happens only when full and the reader is not freeing a slot this cycle
    assign drop_c    = push_c & fifo_full & ~evt_ready;
    assign seq_bad_c = push_c & state_in[MANT_BIT] & has_mant_q &
                       (state_in[MANT_W-1:0] != MANT_W'(mant_last + MANT_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= '0;
            cnt_q      <= '0;
            stall      <= 1'b0;
            has_mant_q <= 1'b0;
            mant_last  <= '0;
            seq_err    <= 1'b0;
            ovf        <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (push_c) prev_q <= state_in;
            if (cnt_clr_c)      cnt_q <= '0;
            else if (cnt_inc_c) cnt_q <= cnt_q + CNT_W'(1);
            stall <= (state_d == STALLED);
            if (push_c && state_in[MANT_BIT]) begin
                has_mant_q <= 1'b1;
                mant_last  <= state_in[MANT_W-1:0];
            end
            // New error events take priority over a same-cycle clear
            if (seq_bad_c)    seq_err <= 1'b1;
            else if (clr_err) seq_err <= 1'b0;
            if (drop_c)       ovf <= 1'b1;
            else if (clr_err) ovf <= 1'b0;
            if (drop_c) begin
                if (clr_err)                    drop_cnt <= DROP_W'(1);
                else if (drop_cnt != '1)        drop_cnt <= drop_cnt + DROP_W'(1);
            end else if (clr_err) begin
                drop_cnt <= '0;
            end
        end
    end

    mon_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (evt_ready),
        .din   (state_in),
        .dout  (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;

endmodule
